alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Two-requester arbiter and sequencer for the shared 4-bit ALU (`alu4bit`).
- Accepts operand/opcode requests from two clients over valid/ready handshakes and grants the ALU round-robin.
- Registers the operands, runs one ALU evaluation, and returns the tagged result (out, carry, zero) on a single response channel with backpressure.
- Sits between the datapath clients and the ALU instance, which it owns.

## Interface
Parameters:
- `W`, 4, operand/result width; fixed to the ALU width and not meant to be overridden.
- `OPW`, 3, opcode width; matches the ALU select input `s`.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `req0_valid`  in  1  requester 0 has an operation pending.
- `req0_ready`  out  1  requester 0 operation accepted this cycle.
- `req0_a`, `req0_b`  in  W  requester 0 operands.
- `req0_s`  in  OPW  requester 0 opcode.
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`, `req1_s`: same as requester 0, for requester 1.
- `rsp_valid`  out  1  result available.
- `rsp_ready`  in  1  consumer takes result.
- `rsp_id`  out  1  requester that issued the result (0/1).
- `rsp_out`  out  W  ALU result.
- `rsp_carry`  out  1  ALU carry.
- `rsp_zero`  out  1  ALU zero flag.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- FSM has three states: IDLE, EXEC, RESP.
- IDLE:
  - If any `reqN_valid` is high, pick a winner and assert its `reqN_ready` (combinational, this cycle only).
  - At the clock edge, latch the winner's a/b/s and id, then go to EXEC.
  - With no valid request, stay in IDLE.
- EXEC:
  - The ALU sees only the latched operands.
  - At the edge, capture `out`, `carry` and `zero` into the response registers, set `rsp_valid`, and go to RESP.
- RESP:
  - Hold `rsp_*` stable until `rsp_valid && rsp_ready`.
  - On that handshake, clear `rsp_valid`, set `last_gnt <= rsp_id`, and go to IDLE.
- Arbitration:
  - If only one request is valid, it wins.
  - If both are valid, the winner is the requester that is not `last_gnt`.
  - `last_gnt` resets to 1, so requester 0 wins the first tie.
- `reqN_ready` is 0 outside IDLE. At most one ready is high in any cycle.
- Requester rules: `reqN_ready` may depend on `reqN_valid`. A requester must hold valid and payload stable until it sees ready. Payload changes while not ready are ignored.
- Arithmetic and flag semantics are exactly those of `alu4bit`. The arbiter does no width extension and no flag recomputation.
- Reset values: `req0_ready`=0, `req1_ready`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_out`=0, `rsp_carry`=0, `rsp_zero`=0, `busy`=0. State resets to IDLE and `last_gnt` to 1.
- Reset mid-operation: an asserted `rst` in EXEC or RESP drops the in-flight operation with no response. The requester is not notified; a requester that needs the result re-issues after reset.

## Timing
- Accept at edge N (ready high in cycle N-1 to N). `rsp_valid` rises after edge N+1, so it is visible in cycle N+1. Accept-to-response latency is 2 cycles.
- Minimum issue interval is 3 cycles per operation, reached with `rsp_ready` held high.
- A new accept is never in the same cycle as the response handshake; the earliest next accept is the cycle after.
- Both valids arrive in the same cycle: one grant per pass. The loser keeps valid high and is granted on the next IDLE visit; starvation is bounded to 1 operation.
- `rsp_ready` low: stay in RESP indefinitely, with no new accepts and stable outputs.

## Structure
- Shared package `alu_pkg`: the `W`/`OPW` constants, the state encoding (IDLE=2'd0, EXEC=2'd1, RESP=2'd2), and the opcode localparams mirroring `alu4bit`'s `s` encodings.
- One sub-module: the existing `alu4bit`, instantiated once and fed from the operand registers.
- Arbitration logic stays inline; no separate arbiter module.

## Test plan
- Single request: `req0` a=4'b0101, b=4'b0110, s=3'b000. Expect `req0_ready` for 1 cycle, then `rsp_valid` 2 cycles after accept with `rsp_id`=0. `rsp_out`/`rsp_carry`/`rsp_zero` must equal the `alu4bit` golden output for (5,6,0).
- Opcode sweep: s=000..111 on requester 1 with a=5, b=6 and `rsp_ready`=1. Expect 8 responses in order, `rsp_id`=1, each matching the golden output; results spaced exactly 3 cycles apart.
- Contention: both valid from reset, `req0` (a=3, b=3) and `req1` (a=15, b=1). Grant order must be 0,1,0,1 while both stay asserted; `rsp_id` alternates and payloads never cross.
- Backpressure: hold `rsp_ready`=0 for 5 cycles after `rsp_valid`. `rsp_*` must stay stable, both ready outputs stay 0, and `busy`=1. On release, the response completes and the next accept happens the following cycle.
- Reset mid-op: assert `rst` in EXEC. Next cycle expect `rsp_valid`=0, `busy`=0, and no response for that operation. After reset, requester 0 wins a tie.
- Zero/carry corners: a=0, b=0 and a=15, b=1 under the add opcode. `rsp_zero` and `rsp_carry` must match the golden values exactly.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants for the ALU arbiter slice: widths, FSM encoding and
// the opcode map of the alu4bit select input.
package alu_pkg;

    localparam int W   = 4;
    localparam int OPW = 3;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [OPW-1:0] OP_ADD = 3'b000;
    localparam logic [OPW-1:0] OP_SUB = 3'b001;
    localparam logic [OPW-1:0] OP_AND = 3'b010;
    localparam logic [OPW-1:0] OP_OR  = 3'b011;
    localparam logic [OPW-1:0] OP_XOR = 3'b100;
    localparam logic [OPW-1:0] OP_NOT = 3'b101;
    localparam logic [OPW-1:0] OP_SHL = 3'b110;
    localparam logic [OPW-1:0] OP_SHR = 3'b111;

    typedef struct packed {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [OPW-1:0] s;
    } alu_op_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between the two ALU clients, the consumer and the arbiter.
interface alu_arbiter_if;
    import alu_pkg::*;

    logic           req0_valid;
    logic           req0_ready;
    logic [W-1:0]   req0_a;
    logic [W-1:0]   req0_b;
    logic [OPW-1:0] req0_s;

    logic           req1_valid;
    logic           req1_ready;
    logic [W-1:0]   req1_a;
    logic [W-1:0]   req1_b;
    logic [OPW-1:0] req1_s;

    logic           rsp_valid;
    logic           rsp_ready;
    logic           rsp_id;
    logic [W-1:0]   rsp_out;
    logic           rsp_carry;
    logic           rsp_zero;

    logic           busy;

    modport master (
        output req0_valid, req0_a, req0_b, req0_s,
        output req1_valid, req1_a, req1_b, req1_s,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_out, rsp_carry, rsp_zero,
        input  busy
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_s,
        input  req1_valid, req1_a, req1_b, req1_s,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_out, rsp_carry, rsp_zero,
        output busy
    );

endinterface

// File: rtl/alu_arbiter_alu4bit.sv
// Combinational 4-bit ALU shared by both arbiter clients.
// For subtraction, carry is the no-borrow flag (set when a >= b).
module alu4bit
    import alu_pkg::*;
(
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    input  logic [OPW-1:0] s,
    output logic [W-1:0]   out,
    output logic           carry,
    output logic           zero
);

    always_comb begin
        out   = '0;
        carry = 1'b0;
        case (s)
            OP_ADD: {carry, out} = {1'b0, a} + {1'b0, b};
            OP_SUB: {carry, out} = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, 1'b1};
            OP_AND: out = a & b;
            OP_OR:  out = a | b;
            OP_XOR: out = a ^ b;
            OP_NOT: out = ~a;
            OP_SHL: begin
                out   = {a[W-2:0], 1'b0};
                carry = a[W-1];
            end
            OP_SHR: begin
                out   = {1'b0, a[W-1:1]};
                carry = a[0];
            end
            default: begin
                out   = '0;
                carry = 1'b0;
            end
        endcase
    end

    assign zero = (out == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter and sequencer that owns the shared alu4bit and returns
// one tagged result per accepted request on a backpressured response channel.
module alu_arbiter
    import alu_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    alu_arbiter_if.slave  bus
);

    logic [1:0]   state;
    logic         last_gnt;
    alu_op_t      op;
    logic         op_id;

    logic         gnt0;
    logic         gnt1;
    alu_op_t      req0_op;
    alu_op_t      req1_op;

    logic [W-1:0] alu_out;
    logic         alu_carry;
    logic         alu_zero;

    logic         rsp_valid_q;
    logic         rsp_id_q;
    logic [W-1:0] rsp_out_q;
    logic         rsp_carry_q;
    logic         rsp_zero_q;

    assign req0_op = {bus.req0_a, bus.req0_b, bus.req0_s};
    assign req1_op = {bus.req1_a, bus.req1_b, bus.req1_s};

    // On a tie the requester that was not served last wins.
    always_comb begin
        gnt0 = bus.req0_valid && (!bus.req1_valid || last_gnt);
        gnt1 = bus.req1_valid && (!bus.req0_valid || !last_gnt);
    end

    assign bus.req0_ready = (state == ST_IDLE) && gnt0;
    assign bus.req1_ready = (state == ST_IDLE) && gnt1;
    assign bus.busy       = (state != ST_IDLE);

    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_out    = rsp_out_q;
    assign bus.rsp_carry  = rsp_carry_q;
    assign bus.rsp_zero   = rsp_zero_q;

    alu4bit u_alu (
        .a     (op.a),
        .b     (op.b),
        .s     (op.s),
        .out   (alu_out),
        .carry (alu_carry),
        .zero  (alu_zero)
    );

    // Reset anywhere drops the in-flight operation without a response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            last_gnt    <= 1'b1;
            op          <= '0;
            op_id       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_out_q   <= '0;
            rsp_carry_q <= 1'b0;
            rsp_zero_q  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (gnt0 || gnt1) begin
                        op    <= gnt1 ? req1_op : req0_op;
                        op_id <= gnt1;
                        state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    rsp_out_q   <= alu_out;
                    rsp_carry_q <= alu_carry;
                    rsp_zero_q  <= alu_zero;
                    rsp_id_q    <= op_id;
                    rsp_valid_q <= 1'b1;
                    state       <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_valid_q && bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        last_gnt    <= rsp_id_q;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter: single request, opcode sweep,
// contention, backpressure, reset mid-operation and flag corners.
module tb_alu_arbiter;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   last_cyc = 0;

    // Hand-computed results for a=5, b=6 across the opcode map.
    logic [31:0] exp_out [8] = '{32'd11, 32'd15, 32'd4, 32'd7, 32'd3, 32'd10, 32'd10, 32'd2};
    logic [31:0] exp_c   [8] = '{32'd0,  32'd0,  32'd0, 32'd0, 32'd0, 32'd0,  32'd0,  32'd1};

    alu_arbiter_if bus ();

    alu_arbiter u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_rsp(input string tag, input logic [31:0] id, input logic [31:0] out,
                             input logic [31:0] c, input logic [31:0] z);
        check({tag, "_valid"}, 32'(bus.rsp_valid), 1);
        check({tag, "_id"},    32'(bus.rsp_id),    id);
        check({tag, "_out"},   32'(bus.rsp_out),   out);
        check({tag, "_carry"}, 32'(bus.rsp_carry), c);
        check({tag, "_zero"},  32'(bus.rsp_zero),  z);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst            = 1'b1;
        bus.req0_valid = 1'b0;
        bus.req0_a     = '0;
        bus.req0_b     = '0;
        bus.req0_s     = '0;
        bus.req1_valid = 1'b0;
        bus.req1_a     = '0;
        bus.req1_b     = '0;
        bus.req1_s     = '0;
        bus.rsp_ready  = 1'b0;
        step();
        step();

        check("rst_rdy0",  32'(bus.req0_ready), 0);
        check("rst_rdy1",  32'(bus.req1_ready), 0);
        check("rst_valid", 32'(bus.rsp_valid),  0);
        check("rst_id",    32'(bus.rsp_id),     0);
        check("rst_out",   32'(bus.rsp_out),    0);
        check("rst_carry", 32'(bus.rsp_carry),  0);
        check("rst_zero",  32'(bus.rsp_zero),   0);
        check("rst_busy",  32'(bus.busy),       0);

        // Single request on requester 0 with the consumer initially stalled.
        rst            = 1'b0;
        bus.req0_valid = 1'b1;
        bus.req0_a     = 4'd5;
        bus.req0_b     = 4'd6;
        bus.req0_s     = 3'b000;
        #1;
        check("single_rdy0", 32'(bus.req0_ready), 1);
        check("single_rdy1", 32'(bus.req1_ready), 0);
        step();
        bus.req0_valid = 1'b0;
        check("single_exec_busy",  32'(bus.busy),       1);
        check("single_exec_valid", 32'(bus.rsp_valid),  0);
        check("single_exec_rdy0",  32'(bus.req0_ready), 0);
        step();
        check_rsp("single", 0, 11, 0, 0);
        step();
        check("single_hold_valid", 32'(bus.rsp_valid), 1);
        bus.rsp_ready = 1'b1;
        step();
        check("single_done_valid", 32'(bus.rsp_valid), 0);
        check("single_done_busy",  32'(bus.busy),      0);

        // Opcode sweep on requester 1, one op every 3 cycles.
        for (int i = 0; i < 8; i++) begin
            bus.req1_valid = 1'b1;
            bus.req1_a     = 4'd5;
            bus.req1_b     = 4'd6;
            bus.req1_s     = i[2:0];
            #1;
            check("sweep_rdy1", 32'(bus.req1_ready), 1);
            check("sweep_rdy0", 32'(bus.req0_ready), 0);
            step();
            bus.req1_valid = 1'b0;
            check("sweep_exec_valid", 32'(bus.rsp_valid), 0);
            step();
            check_rsp("sweep", 1, exp_out[i], exp_c[i], 0);
            if (i > 0) check("sweep_spacing", 32'(cyc - last_cyc), 3);
            last_cyc = cyc;
            step();
        end

        // Contention from reset: grants alternate 0,1,0,1.
        rst            = 1'b1;
        bus.req0_valid = 1'b1;
        bus.req0_a     = 4'd3;
        bus.req0_b     = 4'd3;
        bus.req0_s     = 3'b000;
        bus.req1_valid = 1'b1;
        bus.req1_a     = 4'd15;
        bus.req1_b     = 4'd1;
        bus.req1_s     = 3'b000;
        step();
        step();
        rst = 1'b0;
        for (int g = 0; g < 4; g++) begin
            #1;
            check("cont_rdy0", 32'(bus.req0_ready), 32'(g[0] == 1'b0));
            check("cont_rdy1", 32'(bus.req1_ready), 32'(g[0]));
            step();
            step();
            if (g[0]) check_rsp("cont", 1, 0, 1, 1);
            else      check_rsp("cont", 0, 6, 0, 0);
            step();
        end

        // Backpressure: response held for 5 stalled cycles.
        bus.rsp_ready = 1'b0;
        #1;
        check("bp_rdy0", 32'(bus.req0_ready), 1);
        step();
        step();
        check_rsp("bp", 0, 6, 0, 0);
        for (int k = 0; k < 5; k++) begin
            step();
            check("bp_hold_valid", 32'(bus.rsp_valid),  1);
            check("bp_hold_out",   32'(bus.rsp_out),    6);
            check("bp_hold_id",    32'(bus.rsp_id),     0);
            check("bp_hold_rdy0",  32'(bus.req0_ready), 0);
            check("bp_hold_rdy1",  32'(bus.req1_ready), 0);
            check("bp_hold_busy",  32'(bus.busy),       1);
        end
        bus.rsp_ready = 1'b1;
        step();
        check("bp_rel_valid", 32'(bus.rsp_valid),  0);
        check("bp_rel_busy",  32'(bus.busy),       0);
        check("bp_rel_rdy1",  32'(bus.req1_ready), 1);
        check("bp_rel_rdy0",  32'(bus.req0_ready), 0);
        step();
        check("bp_next_busy", 32'(bus.busy), 1);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        step();
        check_rsp("bp_next", 1, 0, 1, 1);
        step();

        // Zero corner, then reset during EXEC of a repeated request.
        bus.req0_valid = 1'b1;
        bus.req0_a     = 4'd0;
        bus.req0_b     = 4'd0;
        bus.req0_s     = 3'b000;
        #1;
        check("zero_rdy0", 32'(bus.req0_ready), 1);
        step();
        step();
        check_rsp("zero", 0, 0, 0, 1);
        step();
        check("again_rdy0", 32'(bus.req0_ready), 1);
        step();
        check("midop_busy", 32'(bus.busy), 1);
        rst = 1'b1;
        step();
        check("midop_valid", 32'(bus.rsp_valid), 0);
        check("midop_busy0", 32'(bus.busy),      0);
        rst            = 1'b0;
        bus.req0_a     = 4'd3;
        bus.req0_b     = 4'd3;
        bus.req1_valid = 1'b1;
        #1;
        check("post_rst_rdy0", 32'(bus.req0_ready), 1);
        check("post_rst_rdy1", 32'(bus.req1_ready), 0);
        step();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        check("post_rst_exec_valid", 32'(bus.rsp_valid), 0);
        step();
        check_rsp("post_rst", 0, 6, 0, 0);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
